control_unit: RTL and testbench
===============================

# control_unit

Instruction sequencer for the accumulator processor: fetches 16-bit instructions from a synchronous program memory, decodes them and drives the control inputs of the datapath (`operand`, `sel_a`, `sel_b`, `wr_acc`, `op`) plus data-memory strobes. It sits directly upstream of the datapath. Every instruction executes in a fixed two-cycle FETCH/EXEC sequence.

## Interface
- `PC_WIDTH`, default 11: program counter and instruction-address width.
- `OPCODE_WIDTH`, default 5: opcode field width, in `instr_data[15:11]`.
- `INSTR_WIDTH`, default 16: instruction width; operand field is `instr_data[10:0]`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; `0` clears all state immediately.
- `start`  in  1  leaves IDLE when sampled high.
- `instr_data`  in  16  program-memory read data; registered by the memory, valid in the cycle after `instr_addr` is presented.
- `instr_addr`  out  11  program counter.
- `operand`  out  11  immediate / data-memory address to the datapath.
- `sel_a`  out  2  accumulator source: 0 = memory data, 1 = immediate, 2 = ALU result.
- `sel_b`  out  1  ALU B source: 0 = memory data, 1 = immediate.
- `wr_acc`  out  1  accumulator write enable.
- `op`  out  1  ALU operation: 1 = add, 0 = sub.
- `rd_ram`  out  1  data-memory read strobe.
- `wr_ram`  out  1  data-memory write strobe (store accumulator).
- `halted`  out  1  high while in HALT.

## Operation
- States: IDLE, FETCH, EXEC, HALT.
- IDLE -> FETCH when `start`=1; otherwise stay in IDLE.
- FETCH -> EXEC unconditionally. `instr_addr` = pc.
- EXEC: decode `instr_data`. Drive the controls for exactly this cycle. pc <= pc+1, then go to FETCH. On HLT, go to HALT instead and leave pc unchanged.
- HALT: sticky. Only `reset` exits it. `start` is ignored.
- Opcode decode (`wr_acc`, `sel_a`, `sel_b`, `op`, `rd_ram`, `wr_ram`):
  - HLT 00000: all zero.
  - STO 00001: `wr_ram`=1.
  - LD 00010: `rd_ram`=1, `sel_a`=0, `wr_acc`=1.
  - LDI 00011: `sel_a`=1, `wr_acc`=1.
  - ADD 00100: `rd_ram`=1, `sel_a`=2, `sel_b`=0, `op`=1, `wr_acc`=1.
  - ADDI 00101: `sel_a`=2, `sel_b`=1, `op`=1, `wr_acc`=1.
  - SUB 00110: `rd_ram`=1, `sel_a`=2, `sel_b`=0, `op`=0, `wr_acc`=1.
  - SUBI 00111: `sel_a`=2, `sel_b`=1, `op`=0, `wr_acc`=1.
- Any other opcode: NOP. All controls zero, pc increments.
- `operand` = `instr_data[10:0]` in EXEC, 0 otherwise.
- Outside EXEC, all control outputs are 0. The datapath therefore never sees X controls.
- pc wraps 2047 -> 0 with no flag.

## Timing
- Reset values: state IDLE, pc 0, `instr_addr` 0, every control output 0, `halted` 0.
- Reset is asynchronous. Deassertion takes effect at the next edge. Reset during FETCH or EXEC aborts the instruction, so no strobe is emitted after the reset assertion.
- Latency:
  - `start` sampled high at edge N: FETCH in cycle N+1, first EXEC in cycle N+2.
  - Each instruction takes 2 cycles.
  - The accumulator updates at the rising edge that ends EXEC.
- Control outputs are combinational from the registered state and `instr_data`. `instr_addr` is registered.
- `halted` rises in the cycle after the HLT EXEC.

## Configuration
- `CU_CYCLE_COUNT_EN` defined: adds output `cycle_count` [15:0].
  - Counts every cycle spent in FETCH or EXEC.
  - Frozen in IDLE and HALT.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- Not defined: no port, no counter logic.

## Structure
- Shared package `bip_pkg`:
  - opcode constants (HLT…SUBI);
  - `sel_a` encodings (SEL_MEM, SEL_IMM, SEL_ALU);
  - FSM state encoding;
  - width constants for PC, opcode and instruction.
- Sub-module `instruction_decoder`: purely combinational, opcode -> control bundle, gated by an EXEC enable. `control_unit` holds the FSM, pc and optional counter.

## Test plan
- Reset/idle: reset=0, then 1, `start`=0 for 10 cycles -> `instr_addr`=0, all controls 0, `halted`=0.
- Program LDI 15; ADDI 3; SUBI 4; HLT; `start` pulse -> EXEC cycles show:
  - LDI: `operand`=15, `sel_a`=1, `wr_acc`=1;
  - ADDI: `operand`=3, `sel_a`=2, `sel_b`=1, `op`=1;
  - SUBI: `operand`=4, `op`=0.
  - Then `halted`=1 and `instr_addr` stays at 3. Paired with the datapath, the accumulator ends at 14.
- LD 5; STO 4 -> LD EXEC: `rd_ram`=1, `operand`=5, `sel_a`=0. STO EXEC: `wr_ram`=1, `wr_acc`=0, `operand`=4.
- Illegal opcode 11111 at address 0 -> no strobes, next fetch from address 1.
- pc wrap: NOPs filling the program memory -> `instr_addr` goes 2047 -> 0. Reset asserted mid-EXEC of an ADD -> `wr_acc` drops immediately, state IDLE.
- With `CU_CYCLE_COUNT_EN` defined: LDI; HLT program -> `cycle_count`=4 after halt, unchanged 10 cycles later.

Source files
------------

// File: rtl/bip_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bip_pkg
//  Description : Shared definitions for the accumulator processor control
//                path: instruction field widths, opcode values, accumulator
//                source encodings, sequencer state encoding and the control
//                bundle handed from the decoder to the datapath outputs.
//  Revision    : 1.0  initial release
// ============================================================================
package bip_pkg;

    // Instruction format: [15:11] opcode, [10:0] operand
    localparam int PC_W      = 11;
    localparam int OPC_W     = 5;
    localparam int INSTR_W   = 16;
    localparam int OPERAND_W = INSTR_W - OPC_W;

    // Opcodes
    localparam logic [OPC_W-1:0] OPC_HLT  = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_STO  = 5'b00001;
    localparam logic [OPC_W-1:0] OPC_LD   = 5'b00010;
    localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_ADDI = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00110;
    localparam logic [OPC_W-1:0] OPC_SUBI = 5'b00111;

    // Accumulator source select
    localparam logic [1:0] SEL_MEM = 2'd0;
    localparam logic [1:0] SEL_IMM = 2'd1;
    localparam logic [1:0] SEL_ALU = 2'd2;

    // ALU operation
    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;

    // ALU B source select
    localparam logic SELB_MEM = 1'b0;
    localparam logic SELB_IMM = 1'b1;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Control bundle driven towards the datapath / data memory
    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       wr_acc;
        logic       op;
        logic       rd_ram;
        logic       wr_ram;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage : bip_pkg
`default_nettype wire

// File: rtl/instruction_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_decoder
//  Description : Purely combinational opcode decoder. Produces the datapath
//                control bundle for the current instruction; the bundle is
//                forced to all-zero whenever en is low so the datapath never
//                sees stray strobes outside the execute cycle. Unknown
//                opcodes decode as NOP (all-zero controls).
//  Ports       : en     in   qualifies the decode (high in EXEC only)
//                opcode in   instruction opcode field
//                ctrl   out  control bundle (sel_a, sel_b, wr_acc, op,
//                            rd_ram, wr_ram)
//  Revision    : 1.0  initial release
// ============================================================================
module instruction_decoder
    import bip_pkg::*;
#(
    parameter int OPCODE_WIDTH = OPC_W
) (
    input  logic                    en,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output ctrl_t                   ctrl
);

    always_comb begin
        ctrl = CTRL_NONE;
        if (en) begin
            case (opcode)
                OPCODE_WIDTH'(OPC_STO): begin
                    ctrl.wr_ram = 1'b1;
                end
                OPCODE_WIDTH'(OPC_LD): begin
                    ctrl.rd_ram = 1'b1;
                    ctrl.sel_a  = SEL_MEM;
                    ctrl.wr_acc = 1'b1;
                end
                OPCODE_WIDTH'(OPC_LDI): begin
                    ctrl.sel_a  = SEL_IMM;
                    ctrl.wr_acc = 1'b1;
                end
                OPCODE_WIDTH'(OPC_ADD): begin
                    ctrl.rd_ram = 1'b1;
                    ctrl.sel_a  = SEL_ALU;
                    ctrl.sel_b  = SELB_MEM;
                    ctrl.op     = OP_ADD;
                    ctrl.wr_acc = 1'b1;
                end
                OPCODE_WIDTH'(OPC_ADDI): begin
                    ctrl.sel_a  = SEL_ALU;
                    ctrl.sel_b  = SELB_IMM;
                    ctrl.op     = OP_ADD;
                    ctrl.wr_acc = 1'b1;
                end
                OPCODE_WIDTH'(OPC_SUB): begin
                    ctrl.rd_ram = 1'b1;
                    ctrl.sel_a  = SEL_ALU;
                    ctrl.sel_b  = SELB_MEM;
                    ctrl.op     = OP_SUB;
                    ctrl.wr_acc = 1'b1;
                end
                OPCODE_WIDTH'(OPC_SUBI): begin
                    ctrl.sel_a  = SEL_ALU;
                    ctrl.sel_b  = SELB_IMM;
                    ctrl.op     = OP_SUB;
                    ctrl.wr_acc = 1'b1;
                end
                // HLT and every unassigned opcode keep all controls low
                default: ctrl = CTRL_NONE;
            endcase
        end
    end

endmodule : instruction_decoder
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit
//  Description : Instruction sequencer for the accumulator processor. Runs a
//                fixed FETCH/EXEC pair per instruction from a synchronous
//                (one-cycle read latency) program memory, drives datapath
//                controls combinationally during EXEC only, and parks in a
//                sticky HALT state on HLT.
//  Config      : CU_CYCLE_COUNT_EN  when defined, adds cycle_count[15:0], a
//                saturating count of cycles spent in FETCH or EXEC.
//  Ports       : clk         in   system clock, rising edge
//                reset       in   asynchronous active-low reset
//                start       in   leave IDLE when sampled high
//                instr_data  in   program memory read data
//                instr_addr  out  program counter
//                operand     out  immediate / data address (EXEC only)
//                sel_a       out  accumulator source (mem/imm/alu)
//                sel_b       out  ALU B source (mem/imm)
//                wr_acc      out  accumulator write enable
//                op          out  ALU op, 1 = add, 0 = sub
//                rd_ram      out  data memory read strobe
//                wr_ram      out  data memory write strobe
//                halted      out  high while in HALT
//                cycle_count out  (CU_CYCLE_COUNT_EN only) busy cycle count
//  Revision    : 1.0  initial release
// ============================================================================
module control_unit
    import bip_pkg::*;
#(
    parameter int PC_WIDTH     = PC_W,
    parameter int OPCODE_WIDTH = OPC_W,
    parameter int INSTR_WIDTH  = INSTR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [INSTR_WIDTH-1:0] instr_data,
    output logic [PC_WIDTH-1:0]    instr_addr,
    output logic [PC_WIDTH-1:0]    operand,
    output logic [1:0]             sel_a,
    output logic                   sel_b,
    output logic                   wr_acc,
    output logic                   op,
    output logic                   rd_ram,
    output logic                   wr_ram,
    output logic                   halted
`ifdef CU_CYCLE_COUNT_EN
    ,
    output logic [15:0]            cycle_count
`endif
);

    localparam int OPND_W = INSTR_WIDTH - OPCODE_WIDTH;

    state_t              state, state_nxt;
    logic [PC_WIDTH-1:0] pc, pc_nxt;
    logic                in_exec;
    logic                is_hlt;
    ctrl_t               ctrl;

    wire [OPCODE_WIDTH-1:0] opcode_fld  = instr_data[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    wire [OPND_W-1:0]       operand_fld = instr_data[OPND_W-1:0];

    assign in_exec = (state == ST_EXEC);
    assign is_hlt  = (opcode_fld == OPCODE_WIDTH'(OPC_HLT));

    // ------------------------------------------------------------------
    // State and program counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            pc    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The pc is held through FETCH and EXEC so that the
    // address presented in FETCH is still the one whose data arrives in
    // EXEC; it advances only on the edge that ends a non-HLT EXEC.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_hlt) begin
                    state_nxt = ST_HALT;
                end else begin
                    // Natural wrap at the top of program space
                    pc_nxt    = pc + 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Decode: controls are only live during EXEC
    // ------------------------------------------------------------------
    instruction_decoder #(
        .OPCODE_WIDTH (OPCODE_WIDTH)
    ) u_decoder (
        .en     (in_exec),
        .opcode (opcode_fld),
        .ctrl   (ctrl)
    );

    assign instr_addr = pc;
    assign operand    = in_exec ? PC_WIDTH'(operand_fld) : '0;
    assign sel_a      = ctrl.sel_a;
    assign sel_b      = ctrl.sel_b;
    assign wr_acc     = ctrl.wr_acc;
    assign op         = ctrl.op;
    assign rd_ram     = ctrl.rd_ram;
    assign wr_ram     = ctrl.wr_ram;
    assign halted     = (state == ST_HALT);

`ifdef CU_CYCLE_COUNT_EN
    // ------------------------------------------------------------------
    // Busy-cycle counter: advances in FETCH/EXEC, sticks at all-ones
    // ------------------------------------------------------------------
    logic [15:0] cycle_cnt;
    logic        busy;

    assign busy = (state == ST_FETCH) || (state == ST_EXEC);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
        end else if (busy && (cycle_cnt != 16'hFFFF)) begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end

    assign cycle_count = cycle_cnt;
`endif

endmodule : control_unit
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_unit
//  Description : Self-checking bench for control_unit. A registered program
//                memory and a small accumulator datapath sit around the DUT;
//                expected behaviour comes from an instruction-level model
//                (one FETCH + one EXEC per instruction, pc advancing modulo
//                2048, HLT stopping the machine).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] instr_data;
    logic [10:0] instr_addr;
    logic [10:0] operand;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        wr_acc;
    logic        op;
    logic        rd_ram;
    logic        wr_ram;
    logic        halted;
`ifdef CU_CYCLE_COUNT_EN
    logic [15:0] cycle_count;
`endif

    control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .instr_data (instr_data),
        .instr_addr (instr_addr),
        .operand    (operand),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .wr_acc     (wr_acc),
        .op         (op),
        .rd_ram     (rd_ram),
        .wr_ram     (wr_ram),
        .halted     (halted)
`ifdef CU_CYCLE_COUNT_EN
        ,
        .cycle_count(cycle_count)
`endif
    );

    always #5 clk = ~clk;

    // Program memory with one-cycle registered read
    logic [15:0] pmem [0:2047];
    always @(posedge clk) instr_data <= pmem[instr_addr];

    // Minimal accumulator datapath driven by the DUT controls
    logic [15:0] acc;
    logic [15:0] dmem [0:2047];
    logic [15:0] alu_b;
    assign alu_b = sel_b ? {5'd0, operand} : dmem[operand];
    always @(posedge clk) begin
        if (wr_acc) begin
            case (sel_a)
                2'd0:    acc <= dmem[operand];
                2'd1:    acc <= {5'd0, operand};
                default: acc <= op ? acc + alu_b : acc - alu_b;
            endcase
        end
        if (wr_ram) dmem[operand] <= acc;
    end

    wire [6:0] ctrl_obs = {sel_a, sel_b, wr_acc, op, rd_ram, wr_ram};

    int n_tests = 0;
    int n_fail  = 0;
    int pc_m    = 0;
    int cyc_m   = 0;

    // Expected controls {sel_a, sel_b, wr_acc, op, rd_ram, wr_ram} per opcode
    function automatic logic [6:0] exp_ctrl(input logic [4:0] opc);
        case (opc)
            5'd1:    return 7'b00_0_0_0_0_1; // STO
            5'd2:    return 7'b00_0_1_0_1_0; // LD
            5'd3:    return 7'b01_0_1_0_0_0; // LDI
            5'd4:    return 7'b10_0_1_1_1_0; // ADD
            5'd5:    return 7'b10_1_1_1_0_0; // ADDI
            5'd6:    return 7'b10_0_1_0_1_0; // SUB
            5'd7:    return 7'b10_1_1_0_0_0; // SUBI
            default: return 7'b00_0_0_0_0_0; // HLT / NOP
        endcase
    endfunction

    function automatic logic [15:0] mk(input logic [4:0] opc, input int opnd);
        logic [10:0] f;
        f = opnd[10:0];
        return {opc, f};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bump_cyc();
        if (cyc_m < 65535) cyc_m++;
    endtask

    task automatic check_cycles(input string tag);
`ifdef CU_CYCLE_COUNT_EN
        check(tag, {16'd0, cycle_count}, cyc_m);
`endif
    endtask

    task automatic do_reset();
        step();
        start = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_addr",  {21'd0, instr_addr}, 0);
        check("rst_quiet", {halted, operand, ctrl_obs}, 0);
        repeat (2) step();
        reset = 1'b1;
        pc_m  = 0;
        cyc_m = 0;
        check_cycles("rst_cycles");
    endtask

    // Pulse start, then follow up to max_instr instructions through the
    // model; stops after an HLT has executed.
    task automatic run(input int max_instr, output bit did_halt);
        logic [15:0] ins;
        bit          done;
        done  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < max_instr && !done; k++) begin
            check("fetch_addr",  {21'd0, instr_addr}, pc_m);
            check("fetch_quiet", {halted, operand, ctrl_obs}, 0);
            bump_cyc();
            step();
            ins = pmem[pc_m];
            check("exec_ctrl", {operand, ctrl_obs}, {ins[10:0], exp_ctrl(ins[15:11])});
            check("exec_addr", {21'd0, instr_addr}, pc_m);
            bump_cyc();
            step();
            if (ins[15:11] == 5'd0) begin
                done = 1'b1;
                check("halt_state", {halted, operand, ctrl_obs}, {1'b1, 18'd0});
            end else begin
                pc_m = (pc_m + 1) % 2048;
            end
        end
        did_halt = done;
    endtask

    task automatic check_sticky(input int n);
        start = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            check("sticky_halt", {halted, operand, ctrl_obs}, {1'b1, 18'd0});
            check("sticky_addr", {21'd0, instr_addr}, pc_m);
        end
        start = 1'b0;
        check_cycles("sticky_cycles");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit h;
        int len;
        reset = 1'b0;
        start = 1'b0;
        acc   = 16'd0;
        for (int i = 0; i < 2048; i++) begin
            pmem[i] = 16'd0;
            dmem[i] = 16'd0;
        end

        // Reset, then idle with start low
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_addr",  {21'd0, instr_addr}, 0);
            check("idle_quiet", {halted, operand, ctrl_obs}, 0);
        end
        check_cycles("idle_cycles");

        // LDI 15; ADDI 3; SUBI 4; HLT  -> acc = 15 + 3 - 4
        pmem[0] = mk(5'd3, 15);
        pmem[1] = mk(5'd5, 3);
        pmem[2] = mk(5'd7, 4);
        pmem[3] = mk(5'd0, 0);
        do_reset();
        acc = 16'd0;
        run(10, h);
        check("prog1_halted", {31'd0, h}, 1);
        check("prog1_pc", pc_m, 3);
        check("prog1_acc", {16'd0, acc}, 14);
        check_sticky(10);

        // LD 5; STO 4; HLT
        pmem[0] = mk(5'd2, 5);
        pmem[1] = mk(5'd1, 4);
        pmem[2] = mk(5'd0, 0);
        dmem[5] = 16'h1234;
        do_reset();
        run(10, h);
        check("prog2_halted", {31'd0, h}, 1);
        check("prog2_acc",  {16'd0, acc}, 32'h1234);
        check("prog2_store", {16'd0, dmem[4]}, 32'h1234);

        // Illegal opcode at address 0, then HLT: 4 busy cycles
        pmem[0] = mk(5'b11111, 11'h5A5);
        pmem[1] = mk(5'd0, 0);
        do_reset();
        run(10, h);
        check("nop_halted", {31'd0, h}, 1);
        check("nop_pc", pc_m, 1);
        check_sticky(10);

        // pc wrap: memory full of non-HLT illegal opcodes
        for (int i = 0; i < 2048; i++)
            pmem[i] = mk(5'($urandom_range(8, 31)), int'($urandom));
        do_reset();
        run(2050, h);
        check("wrap_nohalt", {31'd0, h}, 0);
        check("wrap_pc", pc_m, 2);

        // Reset asserted in the middle of an ADD execute cycle
        pmem[0] = mk(5'd4, 7);
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("abort_pre", {25'd0, ctrl_obs}, {25'd0, exp_ctrl(5'd4)});
        #2;
        reset = 1'b0;
        #1;
        check("abort_quiet", {halted, operand, ctrl_obs}, 0);
        check("abort_addr",  {21'd0, instr_addr}, 0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_idle", {halted, instr_addr, operand, ctrl_obs}, 0);
        end
        pc_m  = 0;
        cyc_m = 0;
        check_cycles("abort_cycles");

        // Randomized programs of arbitrary non-HLT opcodes ending in HLT
        for (int it = 0; it < 8; it++) begin
            len = int'($urandom_range(1, 24));
            for (int i = 0; i < len; i++)
                pmem[i] = mk(5'($urandom_range(1, 31)), int'($urandom));
            pmem[len] = mk(5'd0, int'($urandom));
            do_reset();
            run(len + 1, h);
            check("rand_halted", {31'd0, h}, 1);
            check("rand_pc", pc_m, len);
            check_sticky(3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_control_unit
`default_nettype wire
